// File: rtl/add_sub_acc.sv
// Registered add/subtract unit with an internal accumulator, a valid/ready
// handshake on both sides, optional unsigned saturation and a sticky carry flag.
module add_sub_acc #(
    parameter int W   = 8,
    parameter int SAT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] SUM,
    output logic         CARRY,
    output logic         OVERFLOW,
    input  logic         clr_sticky,
    output logic         sticky_carry
);

    logic [W-1:0] acc_q;
    logic [W-1:0] lhs;
    logic [W-1:0] rhs;
    logic [W:0]   raw;
    logic         is_sub;
    logic         is_acc;
    logic         carry_d;
    logic         ovf_d;
    logic [W-1:0] sum_d;
    logic         accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        is_acc  = op[1];
        is_sub  = op[0];
        lhs     = is_acc ? acc_q : A;
        rhs     = is_acc ? A : B;
        raw     = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        sum_d   = '0;
        if (is_sub) begin
            raw     = {1'b0, lhs} - {1'b0, rhs};
            carry_d = (lhs < rhs);
            ovf_d   = (lhs[W-1] != rhs[W-1]) && (raw[W-1] != lhs[W-1]);
        end else begin
            raw     = {1'b0, lhs} + {1'b0, rhs};
            carry_d = raw[W];
            ovf_d   = (lhs[W-1] == rhs[W-1]) && (raw[W-1] != lhs[W-1]);
        end
        // Saturation clamps only SUM; flags still describe the unclamped result.
        if ((SAT != 0) && carry_d) begin
            sum_d = is_sub ? '0 : '1;
        end else begin
            sum_d = raw[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            SUM          <= '0;
            CARRY        <= 1'b0;
            OVERFLOW     <= 1'b0;
            sticky_carry <= 1'b0;
            acc_q        <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                SUM       <= sum_d;
                CARRY     <= carry_d;
                OVERFLOW  <= ovf_d;
                if (is_acc) begin
                    acc_q <= sum_d;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // A new carry takes priority over a simultaneous clear.
            if (accept && carry_d) begin
                sticky_carry <= 1'b1;
            end else if (clr_sticky) begin
                sticky_carry <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_add_sub_acc.sv
// Scoreboard bench for add_sub_acc: wrap and saturating instances share stimulus
// and are checked against an integer-arithmetic reference model.
module tb_add_sub_acc;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [1:0]   op;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         out_ready;
    logic         clr_sticky;

    logic         in_ready0, out_valid0, carry0, ovf0, sticky0;
    logic         in_ready1, out_valid1, carry1, ovf1, sticky1;
    logic [W-1:0] sum0, sum1;

    typedef struct packed {
        logic [W-1:0] s0;
        logic         c0;
        logic         v0;
        logic [W-1:0] s1;
        logic         c1;
        logic         v1;
    } exp_t;

    exp_t         q[$];
    int           vectors = 0;
    int           errs    = 0;
    int           acc0    = 0;
    int           acc1    = 0;
    logic         exp_sticky0 = 1'b0;
    logic         exp_sticky1 = 1'b0;
    logic         model_valid = 1'b0;

    add_sub_acc #(.W(W), .SAT(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .op(op), .A(a_in), .B(b_in), .out_valid(out_valid0), .out_ready(out_ready),
        .SUM(sum0), .CARRY(carry0), .OVERFLOW(ovf0),
        .clr_sticky(clr_sticky), .sticky_carry(sticky0)
    );

    add_sub_acc #(.W(W), .SAT(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .op(op), .A(a_in), .B(b_in), .out_valid(out_valid1), .out_ready(out_ready),
        .SUM(sum1), .CARRY(carry1), .OVERFLOW(ovf1),
        .clr_sticky(clr_sticky), .sticky_carry(sticky1)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void ref_op(input int sat, input logic [1:0] o, input int accv,
                                   input int a, input int b,
                                   output int s, output logic c, output logic v);
        int l, r, res, sl, sr, sres;
        l  = o[1] ? accv : a;
        r  = o[1] ? a : b;
        sl = (l >= 128) ? l - 256 : l;
        sr = (r >= 128) ? r - 256 : r;
        if (o[0]) begin
            res  = l - r;
            sres = sl - sr;
        end else begin
            res  = l + r;
            sres = sl + sr;
        end
        c = (res > 255) || (res < 0);
        v = (sres > 127) || (sres < -128);
        if (sat != 0 && c) s = o[0] ? 0 : 255;
        else               s = (res % 256 + 256) % 256;
    endfunction

    task automatic step(input logic iv, input logic [1:0] o, input int a, input int b,
                        input logic ordy, input logic clr, input logic rn);
        logic acc_ok;
        int   s0, s1;
        logic c0, v0, c1, v1;
        exp_t e;
        in_valid   = iv;
        op         = o;
        a_in       = W'(a);
        b_in       = W'(b);
        out_ready  = ordy;
        clr_sticky = clr;
        rst_n      = rn;
        acc_ok = rn && iv && (!model_valid || ordy);
        ref_op(0, o, acc0, a, b, s0, c0, v0);
        ref_op(1, o, acc1, a, b, s1, c1, v1);
        @(posedge clk);
        if (!rn) begin
            q.delete();
            model_valid = 1'b0;
            acc0 = 0;
            acc1 = 0;
            exp_sticky0 = 1'b0;
            exp_sticky1 = 1'b0;
        end else begin
            if (acc_ok) begin
                e.s0 = W'(s0); e.c0 = c0; e.v0 = v0;
                e.s1 = W'(s1); e.c1 = c1; e.v1 = v1;
                q.push_back(e);
                model_valid = 1'b1;
                if (o[1]) begin
                    acc0 = s0;
                    acc1 = s1;
                end
            end else if (ordy) begin
                model_valid = 1'b0;
            end
            if (acc_ok && c0) exp_sticky0 = 1'b1;
            else if (clr)     exp_sticky0 = 1'b0;
            if (acc_ok && c1) exp_sticky1 = 1'b1;
            else if (clr)     exp_sticky1 = 1'b0;
        end
        #1;
    endtask

    // Monitor: checks held outputs every cycle, retires an entry on each transfer.
    always @(negedge clk) begin
        chk("out_valid_wrap", 64'(out_valid0), 64'(q.size() > 0));
        chk("out_valid_sat", 64'(out_valid1), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready0), 64'((q.size() == 0) || out_ready));
        chk("sticky_wrap", 64'(sticky0), 64'(exp_sticky0));
        chk("sticky_sat", 64'(sticky1), 64'(exp_sticky1));
        if (q.size() > 0) begin
            chk("sum_wrap", 64'(sum0), 64'(q[0].s0));
            chk("carry_wrap", 64'(carry0), 64'(q[0].c0));
            chk("ovf_wrap", 64'(ovf0), 64'(q[0].v0));
            chk("sum_sat", 64'(sum1), 64'(q[0].s1));
            chk("carry_sat", 64'(carry1), 64'(q[0].c1));
            chk("ovf_sat", 64'(ovf1), 64'(q[0].v1));
            if (rst_n && out_ready) void'(q.pop_front());
        end
    end

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC_ADD = 2'b10, ACC_SUB = 2'b11;

    initial begin
        in_valid = 0; op = ADD; a_in = 0; b_in = 0; out_ready = 1; clr_sticky = 0; rst_n = 0;
        step(1, ADD, 8'h12, 8'h34, 1, 0, 0);
        step(1, ADD, 8'h12, 8'h34, 1, 0, 0);
        chk("rst_out_valid", 64'(out_valid0), 64'd0);
        chk("rst_sum", 64'(sum0), 64'd0);
        chk("rst_flags", 64'({carry0, ovf0, sticky0}), 64'd0);
        chk("rst_in_ready", 64'(in_ready0), 64'd1);

        step(1, ADD, 8'hFF, 8'h01, 1, 0, 1);
        chk("add_ff_01", 64'({out_valid0, sum0, carry0, ovf0, sticky0}), 64'({1'b1, 8'h00, 1'b1, 1'b0, 1'b1}));
        step(1, ADD, 8'h7F, 8'h01, 1, 0, 1);
        chk("add_7f_01", 64'({sum0, carry0, ovf0}), 64'({8'h80, 1'b0, 1'b1}));
        step(1, SUB, 8'h00, 8'h01, 1, 0, 1);
        chk("sub_00_01", 64'({sum0, carry0, sum1}), 64'({8'hFF, 1'b1, 8'h00}));

        for (int i = 0; i < 3; i++) begin
            step(1, ADD, 8'h05, 8'h06, 0, 0, 1);
            chk("stall_in_ready", 64'(in_ready0), 64'd0);
            chk("stall_sum", 64'(sum0), 64'hFF);
        end
        step(1, ADD, 8'h05, 8'h06, 1, 0, 1);
        chk("stall_release", 64'(sum0), 64'h0B);

        step(0, ADD, 0, 0, 1, 0, 0);
        step(1, ACC_ADD, 8'h80, 0, 1, 0, 1);
        chk("acc_add_1", 64'(sum0), 64'h80);
        step(1, ACC_ADD, 8'h80, 0, 1, 0, 1);
        chk("acc_add_2", 64'({sum0, carry0, sum1}), 64'({8'h00, 1'b1, 8'hFF}));
        step(1, ACC_SUB, 8'h01, 0, 1, 0, 1);
        chk("acc_sub", 64'({sum0, carry0}), 64'({8'hFF, 1'b1}));

        step(1, ADD, 8'hFF, 8'h01, 1, 1, 1);
        chk("sticky_set_wins", 64'(sticky0), 64'd1);
        step(0, ADD, 0, 0, 1, 1, 1);
        chk("sticky_clear", 64'(sticky0), 64'd0);

        step(0, ADD, 0, 0, 1, 0, 0);
        step(1, ACC_ADD, 8'h55, 0, 0, 0, 1);
        step(1, ACC_ADD, 8'h01, 0, 0, 0, 0);
        chk("rst_discard", 64'(out_valid0), 64'd0);
        step(1, ACC_ADD, 8'h01, 0, 1, 0, 1);
        chk("acc_after_rst", 64'(sum0), 64'h01);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, 2'($urandom), int'($urandom % 256), int'($urandom % 256),
                 ($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 200) != 0);
        end
        step(0, ADD, 0, 0, 1, 0, 1);
        step(0, ADD, 0, 0, 1, 0, 1);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
